// File: rtl/d_debounce_sync.sv
// -----------------------------------------------------------------------------
// d_debounce_sync
//
// Purpose:
//   Conditions a raw, asynchronous, possibly bouncing single-bit input before it
//   feeds the D flip-flop / latch stages. The input is first synchronised into
//   the clk domain through a flop chain. A two-state filter (STABLE / WAIT) then
//   lets a level change reach q only after the synchronised value has differed
//   from q for DEBOUNCE_CYCLES consecutive clocks. One-cycle rise/fall pulses
//   are produced on the same edge that q changes.
//
// Parameters:
//   SYNC_STAGES      number of synchroniser flops on d_raw (>= 2)
//   DEBOUNCE_CYCLES  consecutive differing cycles needed before q flips (>= 1)
//   CNT_W            width of glitch_cnt (only meaningful with the option below)
//
// Ports:
//   clk         in   system clock, all state updates on the rising edge
//   rst         in   synchronous reset, active-high
//   d_raw       in   asynchronous raw input
//   q           out  debounced, synchronised level (registered)
//   rise        out  one-cycle pulse in the first cycle q reads 1 (registered)
//   fall        out  one-cycle pulse in the first cycle q reads 0 (registered)
//   glitch_cnt  out  saturating count of rejected glitches (optional)
//
// Optional feature:
//   Define DEBOUNCE_GLITCH_CNT_EN to add the glitch_cnt output and its counter.
//   Without the macro the port and its logic are absent; all other behaviour is
//   unchanged.
// -----------------------------------------------------------------------------
module d_debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_raw,
  output logic             q,
  output logic             rise,
  output logic             fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] glitch_cnt
`endif
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so this width never wraps.
  localparam int CW_RAW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_WAIT   = 1'b1
  } state_t;

  // Elaboration-time guard against illegal parameter combinations.
  if ((SYNC_STAGES < 2) || (DEBOUNCE_CYCLES < 1) || (CNT_W < 1)) begin : g_bad_params
    $error("d_debounce_sync: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   d_s_s;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          cnt_nxt_s;
  logic                   q_r;
  logic                   q_nxt_s;
  logic                   rise_r;
  logic                   fall_r;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                   glitch_s;
  logic [CNT_W-1:0]       glitch_cnt_r;
`endif

  // Synchroniser chain: d_raw enters at bit 0, the last stage is the only
  // value the filter ever looks at.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d_raw};
    end
  end

  assign d_s_s = sync_r[SYNC_STAGES-1];

  // Filter next-state logic: decides when the synchronised level is accepted.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    q_nxt_s     = q_r;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    glitch_s    = 1'b0;
`endif
    case (state_r)
      ST_STABLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (d_s_s != q_r) begin
          if (DEBOUNCE_CYCLES == 1) begin
            // A single differing sample is enough: accept immediately.
            q_nxt_s     = d_s_s;
            state_nxt_s = ST_STABLE;
          end else begin
            // This sample is the first of the run, hence the count starts at 1.
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_ONE;
          end
        end else begin
          state_nxt_s = ST_STABLE;
        end
      end
      ST_WAIT: begin
        if (d_s_s == q_r) begin
          // Input returned to the current level before the run completed.
          state_nxt_s = ST_STABLE;
          cnt_nxt_s   = CNT_ZERO;
`ifdef DEBOUNCE_GLITCH_CNT_EN
          glitch_s    = 1'b1;
`endif
        end else if (cnt_r == CNT_LAST) begin
          q_nxt_s     = d_s_s;
          state_nxt_s = ST_STABLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_STABLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Filter state, debounced level and edge pulses. Reset overrides every
  // transition and never produces a pulse, even when q was high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_STABLE;
      cnt_r   <= CNT_ZERO;
      q_r     <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      q_r     <= q_nxt_s;
      rise_r  <= q_nxt_s & ~q_r;
      fall_r  <= ~q_nxt_s & q_r;
    end
  end

  assign q    = q_r;
  assign rise = rise_r;
  assign fall = fall_r;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  // Saturating count of rejected glitches; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt_r <= {CNT_W{1'b0}};
    end else if (glitch_s && (glitch_cnt_r != {CNT_W{1'b1}})) begin
      glitch_cnt_r <= glitch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      glitch_cnt_r <= glitch_cnt_r;
    end
  end

  assign glitch_cnt = glitch_cnt_r;
`endif

endmodule

// File: tb/tb_d_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_d_debounce_sync
//
// Two instances: u_dut (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=4) and u_dut1
// (DEBOUNCE_CYCLES=1). Stimulus pushes hand-computed pulse events (which DUT,
// kind, edge number) into a scoreboard queue; a negedge monitor pops events
// falling due and compares q/rise/fall of both instances every cycle.
// -----------------------------------------------------------------------------
module tb_d_debounce_sync;

  logic clk = 1'b0;
  logic rst;
  logic d_raw;
  logic d_raw1;
  logic q, rise, fall;
  logic q1, rise1, fall1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [3:0] glitch_cnt;
  logic [7:0] glitch_cnt1;
`endif

  d_debounce_sync #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(4)
  ) u_dut (
    .clk(clk), .rst(rst), .d_raw(d_raw),
    .q(q), .rise(rise), .fall(fall)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(glitch_cnt)
`endif
  );

  d_debounce_sync #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_W(8)
  ) u_dut1 (
    .clk(clk), .rst(rst), .d_raw(d_raw1),
    .q(q1), .rise(rise1), .fall(fall1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(glitch_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Rising-edge number; after edge k (and before edge k+1) it reads k.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef enum logic [1:0] {EV_RISE, EV_FALL, EV_QCLR} ev_kind_t;
  typedef struct {
    int       id;
    ev_kind_t kind;
    int       edge_no;
  } ev_t;

  ev_t        sb_q[$];
  ev_t        mon_ev;
  int         n_vec = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;
  logic [1:0] exp_lvl = 2'b00;
  logic [1:0] exp_rise;
  logic [1:0] exp_fall;

  task automatic check_out(input int id, input logic aq, input logic ar, input logic af);
    n_vec++;
    if ({aq, ar, af} !== {exp_lvl[id], exp_rise[id], exp_fall[id]}) begin
      n_err++;
      $display("FAIL out_dut%0d edge %0d: q/rise/fall got %b%b%b want %b%b%b",
               id, edge_cnt, aq, ar, af, exp_lvl[id], exp_rise[id], exp_fall[id]);
    end
  endtask

  // Monitor: apply every event due at this edge, then compare both DUTs.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_rise = 2'b00;
      exp_fall = 2'b00;
      while ((sb_q.size() > 0) && (sb_q[0].edge_no <= edge_cnt)) begin
        mon_ev = sb_q.pop_front();
        if (mon_ev.edge_no != edge_cnt) begin
          n_err++;
          $display("FAIL event_order: event for edge %0d seen at edge %0d",
                   mon_ev.edge_no, edge_cnt);
        end
        case (mon_ev.kind)
          EV_RISE: begin exp_rise[mon_ev.id] = 1'b1; exp_lvl[mon_ev.id] = 1'b1; end
          EV_FALL: begin exp_fall[mon_ev.id] = 1'b1; exp_lvl[mon_ev.id] = 1'b0; end
          default: exp_lvl[mon_ev.id] = 1'b0;
        endcase
      end
      check_out(0, q, rise, fall);
      check_out(1, q1, rise1, fall1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int id, input ev_kind_t kind, input int edge_no);
    ev_t e;
    e.id = id;
    e.kind = kind;
    e.edge_no = edge_no;
    sb_q.push_back(e);
  endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
  task automatic chk_glitch(input string name, input logic [3:0] want);
    n_vec++;
    if (glitch_cnt !== want) begin
      n_err++;
      $display("FAIL %s: glitch_cnt got %0d want %0d", name, glitch_cnt, want);
    end
  endtask
`endif

  int m;

  initial begin
    rst    = 1'b1;
    d_raw  = 1'b1;
    d_raw1 = 1'b0;

    // 1: reset held 3 cycles with d_raw high, then release.
    tick(1);
    mon_en = 1'b1;
    tick(2);
    rst = 1'b0;
    push(0, EV_RISE, edge_cnt + 6);
    tick(8);

    // 2: falling edge from q=1.
    d_raw = 1'b0;
    push(0, EV_FALL, edge_cnt + 6);
    tick(8);

    // 3a: high for 3 periods is rejected.
    d_raw = 1'b1;
    tick(3);
    d_raw = 1'b0;
    tick(10);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk_glitch("glitch_3cyc", 4'd1);
`endif

    // 3b: high for 4 periods is accepted.
    d_raw = 1'b1;
    push(0, EV_RISE, edge_cnt + 6);
    tick(4);
    d_raw = 1'b0;
    push(0, EV_FALL, edge_cnt + 6);
    tick(10);

    // 4: one-cycle reset at the 4th edge of a pending rise.
    d_raw = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk_glitch("glitch_rst_clear", 4'd0);
`endif
    push(0, EV_RISE, edge_cnt + 6);
    tick(8);

    // 4b: reset while q=1 drops q with no fall pulse, then re-qualifies.
    m = edge_cnt;
    rst = 1'b1;
    push(0, EV_QCLR, m + 1);
    tick(1);
    rst = 1'b0;
    push(0, EV_RISE, edge_cnt + 6);
    tick(8);
    d_raw = 1'b0;
    push(0, EV_FALL, edge_cnt + 6);
    tick(8);

    // 5: toggling every clock for 50 cycles never moves q.
    for (int i = 0; i < 50; i++) begin
      d_raw = ~d_raw;
      tick(1);
    end
    d_raw = 1'b0;
    tick(10);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk_glitch("glitch_saturate", 4'd15);
`endif

    // 6: DEBOUNCE_CYCLES=1 instance, step then a one-cycle pulse.
    d_raw1 = 1'b1;
    push(1, EV_RISE, edge_cnt + 3);
    tick(5);
    d_raw1 = 1'b0;
    push(1, EV_FALL, edge_cnt + 3);
    tick(5);
    d_raw1 = 1'b1;
    push(1, EV_RISE, edge_cnt + 3);
    tick(1);
    d_raw1 = 1'b0;
    push(1, EV_FALL, edge_cnt + 3);
    tick(6);

    tick(2);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d events left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
